// File: rtl/spi_master_fifo.sv
// SPI master with CPU register window and TX/RX byte FIFOs.
//
// Ports:
//   clk, reset_n      system clock, asynchronous active-low reset
//   addr, dout, din   CPU address, write data (in), read data (out; 'z outside window)
//   wr_en, rd_en      single-cycle CPU write / read strobes
//   sclk, mosi, miso  SPI bus
//   ss_n              active-low slave selects (one per slave)
//
// Register window at BASE_ADDR (offset = addr[2:0]):
//   0 CON    [0] EN [1] CPOL [2] CPHA [3] CONT [4] LSBF [5] FLUSH (self-clearing)
//   1 CLKDIV half-period = CLKDIV+1 clk cycles
//   2 STAT   [0] BUSY [1] TXFULL [2] TXEMPTY [3] RXFULL [4] RXEMPTY [5] RXOVF [6] TXOVF (w1c)
//   3 SSEL   [2:0] selects the ss_n line
//   4 TXDATA write pushes TX FIFO
//   5 RXDATA read returns RX head, rd_en pops
module spi_master_fifo #(
  parameter logic [7:0]  BASE_ADDR  = 8'h80,
  parameter int unsigned SLAVES     = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        addr,
  input  logic [7:0]        dout,
  output logic [7:0]        din,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [SLAVES-1:0] ss_n
);

  localparam int unsigned     PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned     CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StLead, StShift, StGap} state_e;

  // Address decode
  logic [7:0] rel_addr;
  logic       in_win, wr, rd;
  logic [2:0] off;
  assign rel_addr = addr - BASE_ADDR;
  assign in_win   = rel_addr < 8'd8;
  assign off      = addr[2:0];
  assign wr       = wr_en & in_win;
  assign rd       = rd_en & in_win;

  // Control registers
  logic [4:0] con_q;
  logic [7:0] clkdiv_q, ssel_q;
  logic       rxovf_q, txovf_q;
  logic       en, cpol, cpha, cont, lsbf, busy, flush;
  assign en    = con_q[0];
  assign cpol  = con_q[1];
  assign cpha  = con_q[2];
  assign cont  = con_q[3];
  assign lsbf  = con_q[4];
  assign flush = wr && (off == 3'd0) && dout[5];

  // Engine state
  state_e     state_q, state_d;
  logic [7:0] div_q, div_d, sh_q, sh_d, shifted;
  logic [3:0] tog_q, tog_d;
  logic       done_q, done_d, phase_q, phase_d, rxbit_q, rxbit_d;
  logic       tx_pop, rx_push_req, ss_active, half_end, cont_go, lead_edge;

  // FIFOs
  logic [7:0]      tx_mem [FIFO_DEPTH];
  logic [7:0]      rx_mem [FIFO_DEPTH];
  logic [PtrW-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
  logic [CntW-1:0] tx_cnt_q, rx_cnt_q;
  logic            tx_full, tx_empty, rx_full, rx_empty;
  logic            tx_push_req, tx_push, rx_push, rx_pop;
  logic [7:0]      tx_head, rx_head;

  assign tx_full     = tx_cnt_q == Full;
  assign tx_empty    = tx_cnt_q == '0;
  assign rx_full     = rx_cnt_q == Full;
  assign rx_empty    = rx_cnt_q == '0;
  assign tx_head     = tx_mem[tx_rp_q];
  assign rx_head     = rx_mem[rx_rp_q];
  assign tx_push_req = wr && (off == 3'd4);
  // A full FIFO still accepts a push when the other side pops in the same cycle
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);
  assign rx_pop      = rd && (off == 3'd5) && !rx_empty;
  assign rx_push     = rx_push_req && (!rx_full || rx_pop);

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q] <= dout;
    if (rx_push) rx_mem[rx_wp_q] <= shifted;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wp_q <= '0; tx_rp_q <= '0; tx_cnt_q <= '0;
      rx_wp_q <= '0; rx_rp_q <= '0; rx_cnt_q <= '0;
    end else if (flush) begin
      tx_wp_q <= '0; tx_rp_q <= '0; tx_cnt_q <= '0;
      rx_wp_q <= '0; rx_rp_q <= '0; rx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + PtrW'(1);
      if (tx_pop)  tx_rp_q <= tx_rp_q + PtrW'(1);
      if (rx_push) rx_wp_q <= rx_wp_q + PtrW'(1);
      if (rx_pop)  rx_rp_q <= rx_rp_q + PtrW'(1);
      tx_cnt_q <= tx_cnt_q + CntW'(tx_push) - CntW'(tx_pop);
      rx_cnt_q <= rx_cnt_q + CntW'(rx_push) - CntW'(rx_pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      con_q    <= '0;
      clkdiv_q <= '0;
      ssel_q   <= '0;
      rxovf_q  <= 1'b0;
      txovf_q  <= 1'b0;
    end else begin
      if (wr && off == 3'd0) begin
        con_q[0] <= dout[0];
        if (!busy) con_q[4:1] <= dout[4:1];
      end
      if (wr && off == 3'd1 && !busy) clkdiv_q <= dout;
      if (wr && off == 3'd3 && !busy) ssel_q <= dout;
      if (tx_push_req && !tx_push)            txovf_q <= 1'b1;
      else if (wr && off == 3'd2 && dout[6])  txovf_q <= 1'b0;
      if (rx_push_req && !rx_push)            rxovf_q <= 1'b1;
      else if (wr && off == 3'd2 && dout[5])  rxovf_q <= 1'b0;
    end
  end

  // Engine
  assign busy      = state_q != StIdle;
  assign half_end  = div_q == clkdiv_q;
  assign cont_go   = cont && en && !tx_empty;
  assign lead_edge = !tog_q[0];  // odd-numbered toggles are leading edges
  assign shifted   = lsbf ? {rxbit_q, sh_q[7:1]} : {sh_q[6:0], rxbit_q};

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    tog_d       = tog_q;
    done_d      = done_q;
    phase_d     = phase_q;
    sh_d        = sh_q;
    rxbit_d     = rxbit_q;
    tx_pop      = 1'b0;
    rx_push_req = 1'b0;
    ss_active   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en && !tx_empty) begin
          tx_pop  = 1'b1;
          sh_d    = tx_head;
          div_d   = '0;
          state_d = StLead;
        end
      end
      StLead: begin
        ss_active = 1'b1;
        if (half_end) begin
          div_d   = '0;
          tog_d   = '0;
          done_d  = 1'b0;
          phase_d = 1'b0;
          state_d = StShift;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      StShift: begin
        if (done_q) begin
          // RX push cycle; ss_n stays low only when chaining into the next byte
          rx_push_req = 1'b1;
          done_d      = 1'b0;
          div_d       = '0;
          if (cont_go) begin
            ss_active = 1'b1;
            tx_pop    = 1'b1;
            sh_d      = tx_head;
            state_d   = StLead;
          end else begin
            state_d = StGap;
          end
        end else begin
          ss_active = 1'b1;
          if (half_end) begin
            div_d   = '0;
            tog_d   = tog_q + 4'd1;
            phase_d = ~phase_q;
            if (lead_edge ^ cpha) begin
              rxbit_d = miso;
            end else if (tog_q != 4'd0 && tog_q != 4'd15) begin
              // First CPHA=1 leading edge keeps the preloaded bit; the final
              // shift is folded into the RX push value.
              sh_d = shifted;
            end
            if (tog_q == 4'd15) done_d = 1'b1;
          end else begin
            div_d = div_q + 8'd1;
          end
        end
      end
      StGap: begin
        if (half_end) begin
          div_d   = '0;
          state_d = StIdle;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      div_q   <= '0;
      tog_q   <= '0;
      done_q  <= 1'b0;
      phase_q <= 1'b0;
      sh_q    <= '0;
      rxbit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tog_q   <= tog_d;
      done_q  <= done_d;
      phase_q <= phase_d;
      sh_q    <= sh_d;
      rxbit_q <= rxbit_d;
    end
  end

  assign sclk = cpol ^ phase_q;
  assign mosi = lsbf ? sh_q[0] : sh_q[7];

  always_comb begin
    ss_n = '1;
    for (int i = 0; i < SLAVES; i++) begin
      ss_n[i] = !(ss_active && ssel_q[2:0] == 3'(i));
    end
  end

  // CPU read mux
  logic [7:0] rdata;
  always_comb begin
    rdata = 8'h00;
    case (off)
      3'd0:    rdata = {3'b000, con_q};
      3'd1:    rdata = clkdiv_q;
      3'd2:    rdata = {1'b0, txovf_q, rxovf_q, rx_empty, rx_full, tx_empty, tx_full, busy};
      3'd3:    rdata = ssel_q;
      3'd5:    rdata = rx_empty ? 8'h00 : rx_head;
      default: rdata = 8'h00;
    endcase
  end

  assign din = in_win ? rdata : 8'hzz;

endmodule

// File: tb/tb_spi_master_fifo.sv
module tb_spi_master_fifo;

  localparam logic [7:0] ACon  = 8'h80;
  localparam logic [7:0] AClk  = 8'h81;
  localparam logic [7:0] AStat = 8'h82;
  localparam logic [7:0] ASsel = 8'h83;
  localparam logic [7:0] ATx   = 8'h84;
  localparam logic [7:0] ARx   = 8'h85;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] dout = 8'h00;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       miso_inv = 1'b0;
  wire  [7:0] din;
  wire        sclk, mosi, miso;
  wire  [1:0] ss_n;

  int n_checks = 0;
  int n_errors = 0;

  int   obs_low0, obs_low1, obs_seg, obs_rise, obs_per, obs_tail, obs_to;
  logic obs_mosi;

  assign miso = mosi ^ miso_inv;

  always #5 clk = ~clk;

  spi_master_fifo #(
    .BASE_ADDR (8'h80),
    .SLAVES    (2),
    .FIFO_DEPTH(4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .addr   (addr),
    .dout   (dout),
    .din    (din),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .sclk   (sclk),
    .mosi   (mosi),
    .miso   (miso),
    .ss_n   (ss_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    addr  = a;
    dout  = d;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic peek(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a;
    #1;
    d = din;
  endtask

  task automatic pop(output logic [7:0] d);
    @(negedge clk);
    addr  = ARx;
    rd_en = 1'b1;
    #1;
    d = din;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  // Waits for BUSY to rise, then records bus activity until BUSY falls.
  task automatic observe(input int maxc);
    bit started, fin, prev_sclk, prev_low, lowany;
    int r1, r2;
    started = 0; fin = 0; prev_sclk = 0; prev_low = 0; r1 = -1; r2 = -1;
    obs_low0 = 0; obs_low1 = 0; obs_seg = 0; obs_rise = 0; obs_tail = 0; obs_mosi = 1'b0;
    for (int c = 0; c < maxc && !fin; c++) begin
      @(negedge clk);
      addr = AStat;
      #1;
      if (!started && din[0]) begin
        started   = 1;
        prev_sclk = sclk;
      end
      if (started) begin
        if (!din[0]) begin
          fin = 1;
        end else begin
          lowany = (ss_n != 2'b11);
          if (lowany && !prev_low) begin
            obs_seg++;
            if (obs_seg == 1) obs_mosi = mosi;
          end
          prev_low = lowany;
          if (!ss_n[0]) obs_low0++;
          if (!ss_n[1]) obs_low1++;
          obs_tail = lowany ? 0 : obs_tail + 1;
          if (sclk && !prev_sclk) begin
            obs_rise++;
            if (r1 < 0) r1 = c;
            else if (r2 < 0) r2 = c;
          end
          prev_sclk = sclk;
        end
      end
    end
    obs_to  = fin ? 0 : 1;
    obs_per = (r2 >= 0) ? r2 - r1 : 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    int         rises;
    bit         prev;

    // Reset state
    #3;
    check("rst_ss_n", ss_n, 2'b11);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    peek(AStat, d);  check("rst_stat", d, 8'h14);
    peek(ACon, d);   check("rst_con", d, 8'h00);
    peek(AClk, d);   check("rst_clkdiv", d, 8'h00);
    peek(ASsel, d);  check("rst_ssel", d, 8'h00);

    // Out-of-window writes ignored; reserved offsets read zero
    wr(8'h00, 8'hFF);
    wr(8'h88, 8'h1F);
    wr(8'h7F, 8'h1F);
    peek(ACon, d);   check("oow_con", d, 8'h00);
    wr(8'h86, 8'hFF);
    peek(8'h86, d);  check("res6", d, 8'h00);
    peek(8'h87, d);  check("res7", d, 8'h00);

    // Mode 0, MSB first, loopback A5
    wr(AClk, 8'h01);
    peek(AClk, d);   check("clkdiv_rb", d, 8'h01);
    wr(ACon, 8'h01);
    wr(ATx, 8'hA5);
    observe(200);
    check("m0_timeout", obs_to, 0);
    check("m0_low0", obs_low0, 34);
    check("m0_low1", obs_low1, 0);
    check("m0_rise", obs_rise, 8);
    check("m0_period", obs_per, 4);
    check("m0_tail", obs_tail, 3);
    check("m0_mosi0", obs_mosi, 1'b1);
    peek(AStat, d);  check("m0_stat", d, 8'h04);
    pop(d);          check("m0_rx", d, 8'hA5);
    peek(AStat, d);  check("m0_stat2", d, 8'h14);

    // Mode 3, LSB first, 01
    wr(ACon, 8'h17);
    peek(ACon, d);   check("m3_con", d, 8'h17);
    check("m3_idle_sclk", sclk, 1'b1);
    wr(ATx, 8'h01);
    observe(200);
    check("m3_timeout", obs_to, 0);
    check("m3_mosi0", obs_mosi, 1'b1);
    check("m3_rise", obs_rise, 8);
    check("m3_low0", obs_low0, 34);
    check("m3_sclk_after", sclk, 1'b1);
    pop(d);          check("m3_rx", d, 8'h01);

    // Mode 0, LSB first, inverted miso
    wr(ACon, 8'h11);
    miso_inv = 1'b1;
    wr(ATx, 8'h3C);
    observe(200);
    miso_inv = 1'b0;
    check("inv_timeout", obs_to, 0);
    check("inv_mosi0", obs_mosi, 1'b0);
    pop(d);          check("inv_rx", d, 8'hC3);

    // Continuous mode, 3 bytes
    wr(ACon, 8'h08);
    wr(ATx, 8'h11);
    wr(ATx, 8'h22);
    wr(ATx, 8'h33);
    wr(ACon, 8'h09);
    observe(400);
    check("cont_timeout", obs_to, 0);
    check("cont_seg", obs_seg, 1);
    check("cont_low0", obs_low0, 104);
    check("cont_rise", obs_rise, 24);
    check("cont_tail", obs_tail, 3);
    pop(d);          check("cont_rx0", d, 8'h11);
    pop(d);          check("cont_rx1", d, 8'h22);
    pop(d);          check("cont_rx2", d, 8'h33);

    // Writes while busy, EN cleared mid-byte, flush
    wr(ACon, 8'h00);
    wr(ATx, 8'h5A);
    wr(ATx, 8'h6B);
    wr(ACon, 8'h01);
    repeat (6) @(negedge clk);
    wr(AClk, 8'h07);
    wr(ASsel, 8'h01);
    wr(ACon, 8'h02);
    repeat (80) @(negedge clk);
    peek(ACon, d);   check("busy_con", d, 8'h00);
    peek(AClk, d);   check("busy_clkdiv", d, 8'h01);
    peek(ASsel, d);  check("busy_ssel", d, 8'h00);
    peek(AStat, d);  check("en_off_stat", d, 8'h00);
    wr(ACon, 8'h20);
    peek(AStat, d);  check("flush_stat", d, 8'h14);
    peek(ACon, d);   check("flush_con", d, 8'h00);
    pop(d);          check("flush_rx", d, 8'h00);

    // TX overflow
    for (int i = 1; i <= 5; i++) wr(ATx, 8'(i));
    peek(AStat, d);  check("txovf_stat", d, 8'h52);
    wr(AStat, 8'h40);
    peek(AStat, d);  check("txovf_clr", d, 8'h12);
    wr(ACon, 8'h01);
    repeat (250) @(negedge clk);
    peek(AStat, d);  check("txovf_done", d, 8'h0C);
    for (int i = 1; i <= 4; i++) begin
      pop(d);
      check("txovf_rx", d, 32'(i));
    end
    pop(d);          check("txovf_rx_empty", d, 8'h00);

    // RX overflow
    wr(ATx, 8'hA1);
    wr(ATx, 8'hB2);
    wr(ATx, 8'hC3);
    wr(ATx, 8'hD4);
    wr(ATx, 8'hE5);
    repeat (300) @(negedge clk);
    peek(AStat, d);  check("rxovf_stat", d, 8'h2C);
    pop(d);          check("rxovf_rx0", d, 8'hA1);
    pop(d);          check("rxovf_rx1", d, 8'hB2);
    pop(d);          check("rxovf_rx2", d, 8'hC3);
    pop(d);          check("rxovf_rx3", d, 8'hD4);
    pop(d);          check("rxovf_rx4", d, 8'h00);
    wr(AStat, 8'h20);
    peek(AStat, d);  check("rxovf_clr", d, 8'h14);

    // Slave select
    wr(ASsel, 8'h01);
    wr(ATx, 8'h77);
    observe(200);
    check("ss1_low0", obs_low0, 0);
    check("ss1_low1", obs_low1, 34);
    pop(d);          check("ss1_rx", d, 8'h77);
    wr(ASsel, 8'h02);
    wr(ATx, 8'h88);
    observe(200);
    check("ss2_timeout", obs_to, 0);
    check("ss2_lows", obs_low0 + obs_low1, 0);
    check("ss2_rise", obs_rise, 8);
    pop(d);          check("ss2_rx", d, 8'h88);
    wr(ASsel, 8'h00);

    // Reset mid-transfer
    wr(ATx, 8'h99);
    rises = 0;
    prev  = sclk;
    for (int c = 0; c < 200 && rises < 4; c++) begin
      @(negedge clk);
      if (sclk && !prev) rises++;
      prev = sclk;
    end
    check("rst_reach_bit4", rises, 4);
    check("rst_pre_ss", ss_n, 2'b10);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_ss_n", ss_n, 2'b11);
    check("arst_sclk", sclk, 1'b0);
    check("arst_mosi", mosi, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (50) @(negedge clk);
    peek(AStat, d);  check("arst_stat", d, 8'h14);
    peek(ACon, d);   check("arst_con", d, 8'h00);
    pop(d);          check("arst_rx", d, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
